result_display_driver: RTL and testbench
========================================

Name: result_display_driver

Overview:
- Downstream stage of the calculator chip: consumes the 8-bit result bus and drives a 3-digit multiplexed 7-segment display.
- Converts the result to BCD with an iterative double-dabble engine (one shift per clock).
- Scans the three digits with a programmable prescaler and blanks leading zeros.

Parameters:
- SCAN_DIV, 1024: clock cycles each digit stays enabled; legal range >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- value_in  input  8  result to display, unsigned (signed under the optional feature)
- seg_out  output  7  segments, active-high; bit0=a ... bit6=g
- dig_en  output  3  one-hot digit enable, active-high; bit0=ones, bit1=tens, bit2=hundreds
- bcd_out  output  12  latched BCD of the last completed conversion; [11:8]=hundreds
- busy  output  1  high while a conversion is in progress
- conv_done  output  1  one-cycle pulse when bcd_out updates
- neg_led  output  1  sign indicator; tied 0 unless the optional feature is enabled

Behaviour:
- Reset values: bcd_out=0, last_val=0, conv_done=0, busy=0, FSM=IDLE, prescaler=0, digit index=0, dig_en=3'b001, seg_out=7'h3F, neg_led=0.
- FSM states:
  - IDLE: if value_in != last_val, load value_in into the binary shift register, set last_val<=value_in, clear the BCD scratch, set cnt=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge, add 3 to every scratch BCD nibble >= 5, then shift {scratch, binary} left by 1. cnt increments; after the 8th shift (cnt==7) go to DONE.
  - DONE: bcd_out<=scratch, conv_done=1 for exactly this one cycle, then return to IDLE.
- busy = (state != IDLE).
- Latency: capture edge plus 8 shift edges plus 1 DONE edge. bcd_out changes on the 10th rising edge, counting the capture edge as the 1st.
- value_in changes while busy are ignored. On return to IDLE the compare against last_val restarts the conversion if needed, so the final displayed value always tracks the latest input. There is no dead cycle beyond the IDLE compare cycle.
- Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→0. dig_en is registered and one-hot, and is never all-zero.
- seg_out is the decode of the currently selected bcd_out nibble:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles >9 cannot occur; decode them as 00.
- Leading-zero blanking (seg_out=00 while dig_en remains asserted):
  - hundreds: blanked if the hundreds nibble is 0;
  - tens: blanked if both hundreds and tens are 0;
  - ones: never blanked.
- The display always shows the old bcd_out until DONE. There is no partial-result tearing.
- rst_n asserted mid-conversion: immediate abort, all reset values apply. After release, if value_in != 0, a fresh conversion starts.

Optional Feature:
- Macro: DISP_SIGNED_EN.
- Defined:
  - value_in is two's complement. The magnitude |value_in| (0..128, 8-bit unsigned) is what gets converted.
  - neg_led<=value_in[7] of the captured value, updated in the DONE cycle together with bcd_out.
  - Blanking and segment codes are unchanged.
- Undefined: value_in is unsigned 0..255 and neg_led is constant 0.

Test Plan:
- Reset with value_in=0, SCAN_DIV=4 → dig_en=001, seg_out=3F, bcd_out=000, busy=0, conv_done never pulses.
- value_in 0→255 → busy rises after the capture edge. On the 10th edge: bcd_out=0x255, one conv_done pulse, busy=0. Scan shows hundreds 5B, tens 6D, ones 6D.
- value_in=7 → bcd_out=0x007. Hundreds and tens seg_out=00 with their dig_en asserted; ones seg_out=07.
- SCAN_DIV=4 → dig_en sequence 001,010,100,001, each held exactly 4 cycles.
- value_in=100, then 42 on the 3rd busy cycle → bcd_out=0x100 with a conv_done pulse, then a back-to-back reconversion giving bcd_out=0x042 and a second conv_done. Total of exactly 2 pulses.
- rst_n pulsed mid-SHIFT with value_in=200 → outputs return to reset values. After release, bcd_out=0x200 on the 10th edge after the first post-reset capture. With DISP_SIGNED_EN and value_in=8'h85 → bcd_out=0x123, neg_led=1; with 8'h80 → bcd_out=0x128, neg_led=1.

Source files
------------

// File: rtl/result_display_driver.sv
// Result bus to 3-digit multiplexed 7-segment driver: iterative double-dabble BCD
// conversion plus digit scanner with leading-zero blanking. Optional: DISP_SIGNED_EN.
module result_display_driver #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value_in,
  output logic [6:0]  seg_out,
  output logic [2:0]  dig_en,
  output logic [11:0] bcd_out,
  output logic        busy,
  output logic        conv_done,
  output logic        neg_led
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  last_val_q, last_val_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]  dig_q, dig_d;

  logic [7:0]  mag;
  logic        start;
  logic [3:0]  adj_o, adj_t;
  logic [2:0]  adj_h;
  logic [3:0]  nib;
  logic        blank;

`ifdef DISP_SIGNED_EN
  logic sign_q, neg_q;
  assign mag     = value_in[7] ? (~value_in + 8'd1) : value_in;
  assign neg_led = neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (start) sign_q <= value_in[7];
      if (state_q == S_DONE) neg_q <= sign_q;
    end
  end
`else
  assign mag     = value_in;
  assign neg_led = 1'b0;
`endif

  assign start = (state_q == S_IDLE) && (value_in != last_val_q);

  // Hundreds never exceeds 2 for an 8-bit input, so its carry-out bit is dropped.
  assign adj_o = scratch_q[3:0] + ((scratch_q[3:0] >= 4'd5) ? 4'd3 : 4'd0);
  assign adj_t = scratch_q[7:4] + ((scratch_q[7:4] >= 4'd5) ? 4'd3 : 4'd0);
  assign adj_h = scratch_q[10:8] + ((scratch_q[11:8] >= 4'd5) ? 3'd3 : 3'd0);

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d      = mag;
          last_val_d = value_in;
          scratch_d  = '0;
          cnt_d      = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = {adj_h, adj_t, adj_o, bin_q[7]};
        bin_d     = {bin_q[6:0], 1'b0};
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    dig_d   = dig_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      dig_d   = {dig_q[1:0], dig_q[2]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_val_q <= '0;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      dig_q      <= 3'b001;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      dig_q      <= dig_d;
    end
  end

  always_comb begin
    nib   = bcd_q[3:0];
    blank = 1'b0;
    case (dig_q)
      3'b010: begin
        nib   = bcd_q[7:4];
        blank = (bcd_q[11:4] == 8'h00);
      end
      3'b100: begin
        nib   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'h0);
      end
      default: ;
    endcase
  end

  always_comb begin
    seg_out = 7'h00;
    if (!blank) begin
      case (nib)
        4'd0: seg_out = 7'h3F;
        4'd1: seg_out = 7'h06;
        4'd2: seg_out = 7'h5B;
        4'd3: seg_out = 7'h4F;
        4'd4: seg_out = 7'h66;
        4'd5: seg_out = 7'h6D;
        4'd6: seg_out = 7'h7D;
        4'd7: seg_out = 7'h07;
        4'd8: seg_out = 7'h7F;
        4'd9: seg_out = 7'h6F;
        default: seg_out = 7'h00;
      endcase
    end
  end

  assign dig_en    = dig_q;
  assign bcd_out   = bcd_q;
  assign busy      = (state_q != S_IDLE);
  assign conv_done = done_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Self-checking bench for result_display_driver: vector table, hand sequences and
// randomized conversions against an arithmetic decimal model. Honors DISP_SIGNED_EN.
module tb_result_display_driver;

  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  value_in = 8'd0;
  logic [6:0]  seg_out;
  logic [2:0]  dig_en;
  logic [11:0] bcd_out;
  logic        busy, conv_done, neg_led;

  always #5 clk = ~clk;

  result_display_driver #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .seg_out   (seg_out),
    .dig_en    (dig_en),
    .bcd_out   (bcd_out),
    .busy      (busy),
    .conv_done (conv_done),
    .neg_led   (neg_led)
  );

  int n_checks = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  logic [11:0] cur_bcd = 12'h000;
  logic [7:0]  last_v = 8'd0;

  always @(negedge clk) if (conv_done) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  val;
    logic [11:0] bcd;
    logic [6:0]  h, t, o;
    logic        neg;
  } vec_t;

  vec_t tbl[5];

  logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int magnitude(input logic [7:0] v);
`ifdef DISP_SIGNED_EN
    return v[7] ? 256 - int'(v) : int'(v);
`else
    return int'(v);
`endif
  endfunction

  function automatic logic model_neg(input logic [7:0] v);
`ifdef DISP_SIGNED_EN
    return v[7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] model_bcd(input logic [7:0] v);
    int m;
    m = magnitude(v);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // digit: 0 = ones, 1 = tens, 2 = hundreds
  function automatic logic [6:0] model_seg(input logic [11:0] b, input int digit);
    int h, t, o;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (digit == 2) return (h == 0) ? 7'h00 : SEG_TAB[h];
    if (digit == 1) return (h == 0 && t == 0) ? 7'h00 : SEG_TAB[t];
    return SEG_TAB[o];
  endfunction

  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input logic exp_neg);
    @(posedge clk); #1;
    value_in = v;
    @(posedge clk); #1;
    chk("busy_after_capture", busy, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("no_tear_edge9", bcd_out, cur_bcd);
    chk("no_early_done", conv_done, 0);
    @(posedge clk); #1;
    chk("bcd_edge10", bcd_out, exp);
    chk("done_pulse", conv_done, 1);
    chk("busy_clear", busy, 0);
    chk("neg_led", neg_led, exp_neg);
    @(posedge clk); #1;
    chk("done_one_cycle", conv_done, 0);
    cur_bcd = exp;
    last_v  = v;
  endtask

  task automatic check_digits(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
    repeat (3 * SD) begin
      @(negedge clk);
      case (dig_en)
        3'b001:  chk("seg_ones", seg_out, o);
        3'b010:  chk("seg_tens", seg_out, t);
        3'b100:  chk("seg_hundreds", seg_out, h);
        default: chk("dig_onehot", dig_en, 3'b001);
      endcase
    end
  endtask

  function automatic logic [2:0] next_dig(input logic [2:0] d);
    case (d)
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  initial begin
    logic [2:0] prev, cur;
    int guard, hold, p0;
    logic [7:0] v;
    logic [11:0] eb;

`ifdef DISP_SIGNED_EN
    tbl[0] = '{8'h85, 12'h123, 7'h06, 7'h5B, 7'h4F, 1'b1};
    tbl[1] = '{8'h80, 12'h128, 7'h06, 7'h5B, 7'h7F, 1'b1};
    tbl[2] = '{8'h07, 12'h007, 7'h00, 7'h00, 7'h07, 1'b0};
    tbl[3] = '{8'hFF, 12'h001, 7'h00, 7'h00, 7'h06, 1'b1};
    tbl[4] = '{8'h0A, 12'h010, 7'h00, 7'h06, 7'h3F, 1'b0};
`else
    tbl[0] = '{8'd255, 12'h255, 7'h5B, 7'h6D, 7'h6D, 1'b0};
    tbl[1] = '{8'd7,   12'h007, 7'h00, 7'h00, 7'h07, 1'b0};
    tbl[2] = '{8'd100, 12'h100, 7'h06, 7'h3F, 7'h3F, 1'b0};
    tbl[3] = '{8'd10,  12'h010, 7'h00, 7'h06, 7'h3F, 1'b0};
    tbl[4] = '{8'd0,   12'h000, 7'h00, 7'h00, 7'h3F, 1'b0};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dig_en", dig_en, 3'b001);
    chk("rst_seg", seg_out, 7'h3F);
    chk("rst_bcd", bcd_out, 12'h000);
    chk("rst_busy", busy, 0);
    chk("rst_done", conv_done, 0);
    chk("rst_neg", neg_led, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_bcd", bcd_out, 12'h000);
    chk("idle_no_pulses", pulse_cnt, 0);

    // Scan sequence: each digit held exactly SD cycles, rotating ones->tens->hundreds
    prev  = dig_en;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (dig_en == prev && guard < 4 * SD);
    chk("dig_change_seen", dig_en != prev, 1);
    for (int k = 0; k < 4; k++) begin
      cur  = dig_en;
      hold = 0;
      do begin
        @(posedge clk); #1;
        hold++;
      end while (dig_en == cur && hold < 4 * SD);
      chk("dig_hold", hold, SD);
      chk("dig_next", dig_en, next_dig(cur));
    end

    // Vector table
    for (int i = 0; i < 5; i++) begin
      convert(tbl[i].val, tbl[i].bcd, tbl[i].neg);
      check_digits(tbl[i].h, tbl[i].t, tbl[i].o);
    end

    // Back-to-back: input changes on the 3rd busy cycle
    @(posedge clk); #1;
    value_in = 8'd100;
    p0 = pulse_cnt;
    @(posedge clk); #1;
    chk("b2b_busy", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    value_in = 8'd42;
    repeat (7) @(posedge clk);
    #1;
    chk("b2b_first_bcd", bcd_out, model_bcd(8'd100));
    chk("b2b_first_done", conv_done, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_second_bcd", bcd_out, model_bcd(8'd42));
    chk("b2b_second_done", conv_done, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_pulse_count", pulse_cnt - p0, 2);
    cur_bcd = model_bcd(8'd42);
    last_v  = 8'd42;

    // Reset mid-conversion
    @(posedge clk); #1;
    value_in = 8'd200;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", bcd_out, 12'h000);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dig", dig_en, 3'b001);
    chk("mid_rst_seg", seg_out, 7'h3F);
    chk("mid_rst_neg", neg_led, 0);
    @(posedge clk); #1;
    chk("mid_rst_hold_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_capture", busy, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_no_tear", bcd_out, 12'h000);
    @(posedge clk); #1;
    chk("post_rst_bcd", bcd_out, model_bcd(8'd200));
    chk("post_rst_done", conv_done, 1);
    chk("post_rst_neg", neg_led, model_neg(8'd200));
    cur_bcd = model_bcd(8'd200);
    last_v  = 8'd200;

    // Randomized conversions against the decimal model
    repeat (12) begin
      do v = 8'($urandom_range(0, 255)); while (v == last_v);
      eb = model_bcd(v);
      convert(v, eb, model_neg(v));
      check_digits(model_seg(eb, 2), model_seg(eb, 1), model_seg(eb, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
